// File: rtl/basic_computer_pkg.sv
// Shared types and sizes for the basic computer datapath.
// Used by the memory, register and bus blocks.
package basic_computer_pkg;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 4096;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } mem_state_t;

endpackage

// File: rtl/memory_unit_mem_array.sv
// Single-port synchronous word RAM.
// Read data is registered; contents are never reset.
module mem_array #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/memory_unit.sv
// Main memory stage: 4096x16 store behind a rd/wr request
// handshake with fixed read latency and latched address.
import basic_computer_pkg::*;

module memory_unit #(
  parameter int ADDR_W   = basic_computer_pkg::ADDR_W,
  parameter int DATA_W   = basic_computer_pkg::DATA_W,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam bit LAT1 = (READ_LAT == 1);

  mem_state_t        state;
  mem_state_t        state_d;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] dout;
  logic              err_q;
  logic              is_rd;
  logic              idle;
  logic              req_rd;
  logic              req_wr;
  logic              req_bad;
  logic [ADDR_W-1:0] ram_addr;

  assign idle    = (state == IDLE);
  assign req_rd  = idle && rd && !wr;
  assign req_wr  = idle && wr && !rd;
  assign req_bad = idle && rd && wr;

  // The RAM sees the live address only while idle, so a read
  // lands in dout during the acceptance edge itself.
  assign ram_addr = idle ? addr : addr_q;

  mem_array #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (state == WRITE),
    .addr (ram_addr),
    .din  (wdata_q),
    .dout (dout)
  );

  always_comb begin
    state_d = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (req_rd) state_d = LAT1 ? DONE : READ_WAIT;
        else if (req_wr) state_d = WRITE;
      end
      (state == READ_WAIT): begin
        if (cnt == 3'd1) state_d = DONE;
      end
      (state == WRITE): state_d = DONE;
      (state == DONE):  state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      is_rd   <= 1'b0;
    end else begin
      state <= state_d;
      err_q <= req_bad;
      if (req_rd) begin
        addr_q <= addr;
        cnt    <= 3'(READ_LAT - 1);
        is_rd  <= 1'b1;
      end
      if (req_wr) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        is_rd   <= 1'b0;
      end
      if (state == READ_WAIT) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) rdata_q <= dout;
      end
      if (LAT1 && state == DONE && is_rd) rdata_q <= dout;
    end
  end

  // With single-cycle latency the word is shown straight from
  // the RAM during DONE, then held in rdata_q afterwards.
  assign rdata = (LAT1 && state == DONE && is_rd) ? dout : rdata_q;
  assign ready = (state == DONE);
  assign busy  = !idle;
  assign err   = err_q;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit against an array model.
module tb_memory_unit;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic        rd;
  logic        wr;
  logic [15:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  int checks;
  int failures;

  logic [15:0] mem_m [0:4095];
  logic [15:0] rdata_m;
  logic [11:0] pool [0:7];

  always #5 clk = ~clk;

  memory_unit #(.READ_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .wdata (wdata),
    .rd    (rd),
    .wr    (wr),
    .rdata (rdata),
    .ready (ready),
    .busy  (busy),
    .err   (err)
  );

  // Stimulus only: issue one request at posedge+1, then watch
  // a bounded window, scrambling addr/wdata after acceptance.
  task automatic run_op(input bit is_wr, input logic [11:0] a,
                        input logic [15:0] d, output int rdy_at,
                        output int rdy_cnt, output int busy_cnt,
                        output logic [15:0] got);
    addr  = a;
    wdata = d;
    rd    = !is_wr;
    wr    = is_wr;
    @(posedge clk); #1;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = a + 12'd1;
    wdata = ~d;
    rdy_at = -1;
    rdy_cnt = 0;
    busy_cnt = 0;
    got = 'x;
    for (int k = 1; k <= 8; k++) begin
      if (busy) busy_cnt++;
      if (ready) begin
        rdy_cnt++;
        if (rdy_at < 0) rdy_at = k;
        got = rdata;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks += 4;
    if (rdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0000", rdata);
    end
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", ready);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b exp=0", err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rdata_m = 16'h0000;
  endtask

  task automatic test_write_read;
    int at, n, bc;
    logic [15:0] got;
    run_op(1'b1, 12'h0A5, 16'hBEEF, at, n, bc, got);
    mem_m[12'h0A5] = 16'hBEEF;
    checks += 4;
    if (at != 2 || n != 1) begin
      failures++;
      $display("FAIL wr_ready at=%0d cnt=%0d exp at=2 cnt=1", at, n);
    end
    if (bc != 2) begin
      failures++;
      $display("FAIL wr_busy cycles=%0d exp=2", bc);
    end
    if (rdata !== rdata_m) begin
      failures++;
      $display("FAIL wr_keeps_rdata got=%h exp=%h", rdata, rdata_m);
    end
    run_op(1'b0, 12'h0A5, 16'h0000, at, n, bc, got);
    rdata_m = 16'hBEEF;
    if (at != LAT || got !== 16'hBEEF) begin
      failures++;
      $display("FAIL rd_0a5 at=%0d data=%h exp at=%0d data=beef",
               at, got, LAT);
    end
    checks++;
    if (bc != LAT) begin
      failures++;
      $display("FAIL rd_busy cycles=%0d exp=%0d", bc, LAT);
    end
  endtask

  task automatic test_addr_latch;
    int at, n, bc;
    logic [15:0] got;
    run_op(1'b1, 12'h010, 16'h1234, at, n, bc, got);
    run_op(1'b1, 12'h011, 16'h5678, at, n, bc, got);
    mem_m[12'h010] = 16'h1234;
    mem_m[12'h011] = 16'h5678;
    run_op(1'b0, 12'h010, 16'h0000, at, n, bc, got);
    rdata_m = 16'h1234;
    checks += 2;
    if (got !== 16'h1234) begin
      failures++;
      $display("FAIL addr_latch got=%h exp=1234", got);
    end
    if (rdata !== 16'h1234) begin
      failures++;
      $display("FAIL rdata_hold got=%h exp=1234", rdata);
    end
  endtask

  task automatic test_illegal;
    int at, n, bc;
    logic [15:0] got;
    addr  = 12'h0A5;
    wdata = 16'hDEAD;
    rd    = 1'b1;
    wr    = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    wr = 1'b0;
    checks += 3;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_pulse got=%b exp=1", err);
    end
    if (busy !== 1'b0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL err_busy busy=%b ready=%b exp 0 0", busy, ready);
    end
    if (rdata !== rdata_m) begin
      failures++;
      $display("FAIL err_rdata got=%h exp=%h", rdata, rdata_m);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_one_cycle got=%b exp=0", err);
    end
    run_op(1'b0, 12'h0A5, 16'h0000, at, n, bc, got);
    rdata_m = mem_m[12'h0A5];
    checks++;
    if (got !== rdata_m) begin
      failures++;
      $display("FAIL err_no_write got=%h exp=%h", got, rdata_m);
    end
  endtask

  task automatic test_wrap;
    int at, n, bc;
    logic [15:0] got;
    run_op(1'b1, 12'hFFF, 16'h7FFF, at, n, bc, got);
    run_op(1'b1, 12'h000, 16'h0001, at, n, bc, got);
    mem_m[12'hFFF] = 16'h7FFF;
    mem_m[12'h000] = 16'h0001;
    run_op(1'b0, 12'hFFF, 16'h0000, at, n, bc, got);
    checks++;
    if (got !== 16'h7FFF) begin
      failures++;
      $display("FAIL wrap_fff got=%h exp=7fff", got);
    end
    run_op(1'b0, 12'h000, 16'h0000, at, n, bc, got);
    rdata_m = 16'h0001;
    checks++;
    if (got !== 16'h0001) begin
      failures++;
      $display("FAIL wrap_000 got=%h exp=0001", got);
    end
  endtask

  task automatic test_reset_mid_read;
    int at, n, bc, pulses;
    logic [15:0] got;
    addr = 12'hFFF;
    rd   = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    rdata_m = 16'h0000;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || rdata !== 16'h0000) begin
      failures++;
      $display("FAIL rst_mid_rd busy=%b ready=%b rdata=%h exp 0 0 0000",
               busy, ready, rdata);
    end
    pulses = 0;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL rst_mid_rd_ready pulses=%0d exp=0", pulses);
    end
    run_op(1'b0, 12'hFFF, 16'h0000, at, n, bc, got);
    rdata_m = mem_m[12'hFFF];
    checks++;
    if (got !== rdata_m || at != LAT) begin
      failures++;
      $display("FAIL rst_rd_again got=%h at=%0d exp=%h at=%0d",
               got, at, rdata_m, LAT);
    end
  endtask

  task automatic test_reset_mid_write;
    int at, n, bc;
    logic [15:0] got;
    addr  = 12'h010;
    wdata = 16'hAAAA;
    wr    = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rdata_m = 16'h0000;
    run_op(1'b0, 12'h010, 16'h0000, at, n, bc, got);
    rdata_m = mem_m[12'h010];
    checks++;
    if (got !== rdata_m) begin
      failures++;
      $display("FAIL rst_mid_wr got=%h exp=%h", got, rdata_m);
    end
  endtask

  task automatic test_random;
    int at, n, bc;
    logic [15:0] got, d;
    logic [11:0] a;
    bit w;
    for (int i = 0; i < 8; i++) begin
      pool[i] = 12'($urandom);
      d = 16'($urandom);
      run_op(1'b1, pool[i], d, at, n, bc, got);
      mem_m[pool[i]] = d;
    end
    for (int i = 0; i < 30; i++) begin
      a = pool[$urandom_range(0, 7)];
      w = 1'($urandom);
      d = 16'($urandom);
      run_op(w, a, d, at, n, bc, got);
      checks++;
      if (w) begin
        mem_m[a] = d;
        if (at != 2 || n != 1 || rdata !== rdata_m) begin
          failures++;
          $display("FAIL rnd_wr a=%h at=%0d cnt=%0d rdata=%h exp at=2 cnt=1 rdata=%h",
                   a, at, n, rdata, rdata_m);
        end
      end else begin
        rdata_m = mem_m[a];
        if (at != LAT || n != 1 || got !== rdata_m) begin
          failures++;
          $display("FAIL rnd_rd a=%h at=%0d data=%h exp at=%0d data=%h",
                   a, at, got, LAT, rdata_m);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int hits [$];
    logic [11:0] a;
    a = pool[0];
    addr = a;
    rd   = 1'b1;
    for (int k = 1; k <= 3 * (LAT + 1); k++) begin
      @(posedge clk); #1;
      if (ready) begin
        hits.push_back(k);
        checks++;
        if (rdata !== mem_m[a]) begin
          failures++;
          $display("FAIL b2b_data k=%0d got=%h exp=%h", k, rdata, mem_m[a]);
        end
      end
    end
    rd = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    rdata_m = mem_m[a];
    checks++;
    if (hits.size() != 3 || hits[0] != LAT || hits[1] != 2 * LAT + 1) begin
      failures++;
      $display("FAIL b2b_spacing n=%0d first=%0d second=%0d exp n=3 first=%0d second=%0d",
               hits.size(), hits.size() > 0 ? hits[0] : -1,
               hits.size() > 1 ? hits[1] : -1, LAT, 2 * LAT + 1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    test_reset;
    test_write_read;
    test_addr_latch;
    test_illegal;
    test_wrap;
    test_reset_mid_read;
    test_reset_mid_write;
    test_random;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- Main memory stage of the basic computer: 4096 x 16-bit word store addressed directly by the 12-bit address register output.
- Accepts one read or write request at a time through a request/ready handshake with fixed, parameterised read latency.
- Latches the address at acceptance, so the address register may increment or reload while an access is in flight.
- Read data is returned to the common bus; write data is taken from the common bus.

Parameters:
- ADDR_W, 12, address width; memory depth is 2**ADDR_W words.
- DATA_W, 16, word width.
- READ_LAT, 2, cycles from read acceptance to ready/rdata valid; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  ADDR_W  word address from the address register output.
- wdata  input  DATA_W  write data from the common bus.
- rd  input  1  read request, level; sampled only in IDLE.
- wr  input  1  write request, level; sampled only in IDLE.
- rdata  output  DATA_W  read data; holds the last read value.
- ready  output  1  one-cycle completion pulse for both read and write.
- busy  output  1  high whenever state != IDLE.
- err  output  1  one-cycle pulse on an illegal request (rd and wr both high in IDLE).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rdata=0, ready=0, busy=0, err=0, latency counter=0, address/data latches=0. Array contents are not reset.
- Deassertion of rst_n takes effect on the next rising clk edge.
- FSM states: IDLE, READ_WAIT, WRITE, DONE.
- IDLE:
  - rd=1, wr=0 at edge N: latch addr; counter=READ_LAT-1; go to READ_WAIT (or DONE directly if READ_LAT=1).
  - wr=1, rd=0 at edge N: latch addr and wdata; go to WRITE.
  - rd=1 and wr=1: err=1 for exactly one cycle; no access; stay in IDLE.
  - Neither high: stay in IDLE.
- READ_WAIT: decrement the counter each cycle. At zero, register array[latched addr] into rdata and go to DONE.
- WRITE: array[latched addr] <= latched wdata on this edge; go to DONE.
- DONE: ready=1 for this single cycle; next state IDLE.
- Timing:
  - Read: ready high in cycle N+READ_LAT, with rdata valid that same cycle.
  - Write: ready high in cycle N+2, with data committed by edge N+1.
- Back-to-back accesses: a request held high through DONE is accepted on the first IDLE edge after DONE. Minimum request-to-request spacing is therefore READ_LAT+1 cycles for reads and 3 cycles for writes.
- rd/wr/addr/wdata changes while busy=1 are ignored; the latched values govern the in-flight access.
- rdata changes only on read completion. A write never alters rdata, even to the same address.
- Address wrap: addr is exactly ADDR_W bits; 12'hFFF is a legal final word; no out-of-range condition exists.
- Reset mid-access aborts the access. For a write, the array is either written fully or not written, never partially. A write is considered committed only if the edge leaving WRITE occurred before rst_n fell.

Decomposition:
- Shared package basic_computer_pkg:
  - ADDR_W=12, DATA_W=16, MEM_DEPTH=4096.
  - mem_state_t enum {IDLE, READ_WAIT, WRITE, DONE}.
  - The package is shared with the register and bus blocks.
- One sub-module, mem_array: single-port synchronous RAM with we, addr, din, dout and no reset.
- memory_unit owns the FSM, latency counter, input latches, and rdata/ready/err generation.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> rdata=16'h0000, ready=0, busy=0, err=0 immediately, before any clk edge.
- Write/read:
  - Write wdata=16'hBEEF to addr=12'h0A5 -> ready pulses at N+2, busy high for 2 cycles.
  - Then read 12'h0A5 -> ready at N+2 with rdata=16'hBEEF (READ_LAT=2).
- Address latching: issue a read of 12'h010 (holding 16'h1234), then change addr to 12'h011 in the following cycle -> rdata=16'h1234, not the contents of 12'h011.
- Illegal request: rd=1, wr=1 in IDLE -> err=1 for one cycle, busy stays 0, array and rdata unchanged.
- Wrap boundary:
  - Write 16'h7FFF to 12'hFFF, then 16'h0001 to 12'h000.
  - Read both back -> 16'h7FFF and 16'h0001; neither location aliases the other.
- Reset mid-read: drop rst_n during READ_WAIT -> state IDLE, ready never pulses, rdata=0. A subsequent read returns the correct stored value.
